// File: rtl/macarray_param_if.sv
// Bus bundle for macarray_param: job control, status and the three SRAM ports.
// The master modport is the MAC array; the slave modport is the SRAM/host side.
interface macarray_param_if #(
    parameter int DW    = 8,
    parameter int LANES = 8,
    parameter int DIM_W = 4,
    parameter int AW    = 3,
    parameter int OAW   = 4
);
    localparam int WW = DW * LANES;

    logic               start;
    logic [3*DIM_W-1:0] mnt;
    logic               mode;

    logic               en_i;
    logic [AW-1:0]      addr_i;
    logic [WW-1:0]      rdata_i;

    logic               en_w;
    logic [AW-1:0]      addr_w;
    logic [WW-1:0]      rdata_w;

    logic               en_o;
    logic               rw_o;
    logic [OAW-1:0]     addr_o;
    logic [WW-1:0]      wdata_o;
    logic [WW-1:0]      rdata_o;

    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  start, mnt, mode, rdata_i, rdata_w, rdata_o,
        output en_i, addr_i, en_w, addr_w, en_o, rw_o, addr_o, wdata_o,
               busy, done, err
    );

    modport slave (
        output start, mnt, mode, rdata_i, rdata_w, rdata_o,
        input  en_i, addr_i, en_w, addr_w, en_o, rw_o, addr_o, wdata_o,
               busy, done, err
    );
endinterface

// File: rtl/macarray_param.sv
// Parametrised MAC array: OUT(TxM) = IN(TxN) * W(NxM), one output row per pass.
// Reads an IN row, then one W-transpose row per output column, accumulates into a
// row buffer and packs the row into the output SRAM (optionally read-modify-write).
// Optional feature macro: MACARRAY_PARAM_SAT_EN (saturating reduction to OUT_DW;
// when undefined the reduction wraps).
module macarray_param #(
    parameter int DW     = 8,
    parameter int LANES  = 8,
    parameter int MAX_M  = 8,
    parameter int MAX_T  = 8,
    parameter int OUT_DW = 16,
    parameter int DIM_W  = 4,
    parameter int AW     = 3,
    parameter int OAW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    macarray_param_if.master bus
);
    localparam int WW    = DW * LANES;
    localparam int OPW   = WW / OUT_DW;
    localparam int WPR   = MAX_M / OPW;
    localparam int FW    = 2 * DW + $clog2(LANES);
    localparam int RW    = (FW > OUT_DW + 1) ? FW : OUT_DW + 1;
    localparam int MW    = (MAX_M > 1) ? $clog2(MAX_M) : 1;
    localparam int WBW   = (WPR > 1) ? $clog2(WPR) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_IN_RD, S_W_RD, S_MAC, S_O_RD, S_O_WR, S_ZFILL, S_FIN
    } state_t;

    state_t             state, state_nxt;
    logic [DIM_W-1:0]   m_cfg, n_cfg, t_cfg;
    logic               mode_q;
    logic [DIM_W-1:0]   t_cnt, m_cnt;
    logic [WBW-1:0]     w_cnt;
    logic [OAW-1:0]     z_addr;
    logic [WW-1:0]      in_word;
    logic [OUT_DW-1:0]  row_buf [MAX_M];
    logic               err_q;

    logic [DIM_W-1:0]   req_m, req_n, req_t;
    logic               cfg_ok, accept, reject;
    logic               last_m, last_w, last_t, last_z, do_zfill;
    logic [OAW-1:0]     o_addr;
    logic signed [FW-1:0] mac_sum;
    logic [WW-1:0]      wr_word;

    // Reduce a wide signed value to OUT_DW: saturate or wrap depending on build.
    function automatic logic [OUT_DW-1:0] reduce_val(input logic signed [RW-1:0] v);
`ifdef MACARRAY_PARAM_SAT_EN
        if (v[RW-1:OUT_DW-1] != {(RW-OUT_DW+1){v[RW-1]}})
            return v[RW-1] ? {1'b1, {(OUT_DW-1){1'b0}}} : {1'b0, {(OUT_DW-1){1'b1}}};
        return v[OUT_DW-1:0];
`else
        return v[OUT_DW-1:0];
`endif
    endfunction

    assign req_m  = bus.mnt[3*DIM_W-1 -: DIM_W];
    assign req_n  = bus.mnt[2*DIM_W-1 -: DIM_W];
    assign req_t  = bus.mnt[DIM_W-1:0];
    assign cfg_ok = (req_m != '0) && (req_m <= DIM_W'(MAX_M)) &&
                    (req_n != '0) && (req_n <= DIM_W'(LANES)) &&
                    (req_t != '0) && (req_t <= DIM_W'(MAX_T));
    assign accept = (state == S_IDLE) && bus.start && cfg_ok;
    assign reject = (state == S_IDLE) && bus.start && !cfg_ok;

    assign last_m   = (m_cnt == m_cfg - 1'b1);
    assign last_w   = (w_cnt == WBW'(WPR - 1));
    assign last_t   = (t_cnt == t_cfg - 1'b1);
    assign last_z   = (z_addr == OAW'(MAX_T * WPR - 1));
    assign do_zfill = !mode_q && (t_cfg != DIM_W'(MAX_T));
    assign o_addr   = OAW'(int'(t_cnt) * WPR + int'(w_cnt));
    assign bus.err  = err_q;

    // Dot product of the latched IN row with the W-transpose row arriving this cycle.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
        mac_sum = '0;
        for (int n = 0; n < LANES; n++) begin
            if (n < int'(n_cfg))
                mac_sum += FW'($signed(in_word[(LANES-1-n)*DW +: DW])) *
                           FW'($signed(bus.rdata_w[(LANES-1-n)*DW +: DW]));
        end
    end

    // Pack row-buffer slots of word w_cnt; in accumulate mode add the old OUT word.
    always_comb begin
        wr_word = '0;
        for (int s = 0; s < OPW; s++) begin
            if (mode_q)
                wr_word[(OPW-1-s)*OUT_DW +: OUT_DW] = reduce_val(
                    RW'($signed(bus.rdata_o[(OPW-1-s)*OUT_DW +: OUT_DW])) +
                    RW'($signed(row_buf[MW'(int'(w_cnt) * OPW + s)])));
            else
                wr_word[(OPW-1-s)*OUT_DW +: OUT_DW] = row_buf[MW'(int'(w_cnt) * OPW + s)];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and SRAM/status outputs decoded from the current state.
    always_comb begin
        state_nxt   = state;
        bus.en_i    = 1'b0;
        bus.addr_i  = '0;
        bus.en_w    = 1'b0;
        bus.addr_w  = '0;
        bus.en_o    = 1'b0;
        bus.rw_o    = 1'b0;
        bus.addr_o  = '0;
        bus.wdata_o = '0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nxt = S_IN_RD;
            S_IN_RD: begin
                bus.busy   = 1'b1;
                bus.en_i   = 1'b1;
                bus.addr_i = t_cnt[AW-1:0];
                state_nxt  = S_W_RD;
            end
            S_W_RD: begin
                bus.busy   = 1'b1;
                bus.en_w   = 1'b1;
                bus.addr_w = m_cnt[AW-1:0];
                state_nxt  = S_MAC;
            end
            S_MAC: begin
                bus.busy = 1'b1;
                if (!last_m)     state_nxt = S_W_RD;
                else if (mode_q) state_nxt = S_O_RD;
                else             state_nxt = S_O_WR;
            end
            S_O_RD: begin
                bus.busy   = 1'b1;
                bus.en_o   = 1'b1;
                bus.addr_o = o_addr;
                state_nxt  = S_O_WR;
            end
            S_O_WR: begin
                bus.busy    = 1'b1;
                bus.en_o    = 1'b1;
                bus.rw_o    = 1'b1;
                bus.addr_o  = o_addr;
                bus.wdata_o = wr_word;
                if (!last_w)      state_nxt = mode_q ? S_O_RD : S_O_WR;
                else if (!last_t) state_nxt = S_IN_RD;
                else if (do_zfill) state_nxt = S_ZFILL;
                else              state_nxt = S_FIN;
            end
            S_ZFILL: begin
                bus.busy   = 1'b1;
                bus.en_o   = 1'b1;
                bus.rw_o   = 1'b1;
                bus.addr_o = z_addr;
                if (last_z) state_nxt = S_FIN;
            end
            S_FIN: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job configuration, loop counters, IN row latch and row buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            err_q   <= 1'b0;
            m_cfg   <= '0;
            n_cfg   <= '0;
            t_cfg   <= '0;
            mode_q  <= 1'b0;
            t_cnt   <= '0;
            m_cnt   <= '0;
            w_cnt   <= '0;
            z_addr  <= '0;
            in_word <= '0;
            // NOTE: the row buffer is a handful of flops, so it is reset rather than left undefined.
            for (int i = 0; i < MAX_M; i++) row_buf[i] <= '0;
        end else begin
            err_q <= reject;
            case (state)
                S_IDLE: if (accept) begin
                    m_cfg  <= req_m;
                    n_cfg  <= req_n;
                    t_cfg  <= req_t;
                    mode_q <= bus.mode;
                    t_cnt  <= '0;
                end
                S_IN_RD: begin
                    m_cnt <= '0;
                    w_cnt <= '0;
                    for (int i = 0; i < MAX_M; i++) row_buf[i] <= '0;
                end
                S_W_RD: if (m_cnt == '0) in_word <= bus.rdata_i;
                S_MAC: begin
                    row_buf[m_cnt[MW-1:0]] <= reduce_val(RW'(mac_sum));
                    m_cnt <= m_cnt + 1'b1;
                end
                S_O_WR: begin
                    w_cnt <= last_w ? '0 : w_cnt + 1'b1;
                    if (last_w) begin
                        t_cnt  <= t_cnt + 1'b1;
                        z_addr <= OAW'(int'(t_cfg) * WPR);
                    end
                end
                S_ZFILL: z_addr <= z_addr + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_macarray_param.sv
// Self-checking bench for macarray_param: table of uniform-fill jobs with hand-computed
// element values and DONE latencies, plus ERR, busy-START, done-START and reset-abort sequences.
module tb_macarray_param;
    typedef struct {
        logic [11:0] mnt;
        logic        mode;
        logic [7:0]  in_b;
        logic [7:0]  w_b;
        logic [15:0] pre;      // value preloaded into every OUT element
        logic [15:0] exp_in;   // expected element for t<T, m<M
        logic [15:0] exp_out;  // expected element elsewhere
        int          cycles;   // START edge to DONE
        bit          poke;     // also drive START while busy and during DONE
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    macarray_param_if #(.DW(8), .LANES(8), .DIM_W(4), .AW(3), .OAW(4)) bus ();
    macarray_param dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [63:0] in_mem  [8];
    logic [63:0] w_mem   [8];
    logic [63:0] out_mem [16];
    logic [63:0] preload_word = '0;
    logic        preload_req = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt = 0, err_cnt = 0, en_cnt = 0, ovl_cnt = 0;

    vec_t vecs [9];

    // SRAM models with one-cycle read latency.
    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 16; i++) out_mem[i] <= preload_word;
        end else if (bus.en_o && bus.rw_o) begin
            out_mem[bus.addr_o] <= bus.wdata_o;
        end
        if (bus.en_o && !bus.rw_o) bus.rdata_o <= out_mem[bus.addr_o];
        if (bus.en_i) bus.rdata_i <= in_mem[bus.addr_i];
        if (bus.en_w) bus.rdata_w <= w_mem[bus.addr_w];
    end

    // Activity monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.en_o && bus.rw_o) wr_cnt <= wr_cnt + 1;
        if (bus.err) err_cnt <= err_cnt + 1;
        if (bus.en_i || bus.en_w || bus.en_o) en_cnt <= en_cnt + 1;
        if (int'(bus.en_i) + int'(bus.en_w) + int'(bus.en_o) > 1) ovl_cnt <= ovl_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input vec_t v, input int a);
        logic [63:0] word;
        int t, w, mm, tt, col;
        word = '0;
        t  = a / 2;
        w  = a % 2;
        mm = int'(v.mnt[11:8]);
        tt = int'(v.mnt[3:0]);
        for (int s = 0; s < 4; s++) begin
            col = w * 4 + s;
            word[(3-s)*16 +: 16] = (t < tt && col < mm) ? v.exp_in : v.exp_out;
        end
        return word;
    endfunction

    function automatic logic [63:0] ctl_outs();
        return {47'd0, bus.en_i, bus.addr_i, bus.en_w, bus.addr_w, bus.en_o, bus.rw_o,
                bus.addr_o, bus.busy, bus.done, bus.err};
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            in_mem[i] = {8{v.in_b}};
            w_mem[i]  = {8{v.w_b}};
        end
        preload_word = {4{v.pre}};
        @(negedge clk);
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int cycles, wr0, err0, exp_wr;
        load(v);
        wr0  = wr_cnt;
        err0 = err_cnt;
        bus.start = 1'b1;
        bus.mnt   = v.mnt;
        bus.mode  = v.mode;
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 1;
        check($sformatf("v%0d_busy_first", idx), 64'(bus.busy), 64'd1);
        while (!bus.done && cycles < 1000) begin
            if (v.poke && cycles == 3) begin
                bus.start = 1'b1;
                bus.mnt   = 12'h988;
            end
            if (v.poke && cycles == 4) bus.start = 1'b0;
            @(negedge clk);
            cycles++;
        end
        check($sformatf("v%0d_done_cycles", idx), 64'(cycles), 64'(v.cycles));
        check($sformatf("v%0d_busy_at_done", idx), 64'(bus.busy), 64'd0);
        if (v.poke) begin
            bus.start = 1'b1;
            bus.mnt   = v.mnt;
            @(negedge clk);
            bus.start = 1'b0;
            check($sformatf("v%0d_start_at_done_ignored", idx), 64'(bus.busy), 64'd0);
        end
        @(negedge clk);
        exp_wr = int'(v.mnt[3:0]) * 2 + (v.mode ? 0 : (8 - int'(v.mnt[3:0])) * 2);
        check($sformatf("v%0d_no_err", idx), 64'(err_cnt - err0), 64'd0);
        check($sformatf("v%0d_write_count", idx), 64'(wr_cnt - wr0), 64'(exp_wr));
        for (int a = 0; a < 16; a++)
            check($sformatf("v%0d_word%0d", idx, a), out_mem[a], exp_word(v, a));
    endtask

    initial begin
        logic [11:0] bad [4];
        int en0;
        bad[0] = 12'h080;
        bad[1] = 12'h988;
        bad[2] = 12'h880;
        bad[3] = 12'h8F8;

        //          mnt     mode  in     w      pre       exp_in    exp_out  cyc  poke
        vecs[0] = '{12'h888, 1'b0, 8'h01, 8'h01, 16'hABCD, 16'h0008, 16'h0000, 153, 1'b0};
        vecs[1] = '{12'h888, 1'b1, 8'h01, 8'h01, 16'h0008, 16'h0010, 16'h0008, 169, 1'b0};
`ifdef MACARRAY_PARAM_SAT_EN
        vecs[2] = '{12'h888, 1'b0, 8'h7F, 8'h7F, 16'h0000, 16'h7FFF, 16'h0000, 153, 1'b0};
        vecs[3] = '{12'h888, 1'b1, 8'h7F, 8'h7F, 16'h7000, 16'h7FFF, 16'h7000, 169, 1'b0};
        vecs[4] = '{12'h888, 1'b0, 8'h80, 8'h7F, 16'h0000, 16'h8000, 16'h0000, 153, 1'b0};
`else
        vecs[2] = '{12'h888, 1'b0, 8'h7F, 8'h7F, 16'h0000, 16'hF808, 16'h0000, 153, 1'b0};
        vecs[3] = '{12'h888, 1'b1, 8'h7F, 8'h7F, 16'h7000, 16'h6808, 16'h7000, 169, 1'b0};
        vecs[4] = '{12'h888, 1'b0, 8'h80, 8'h7F, 16'h0000, 16'h0400, 16'h0000, 153, 1'b0};
`endif
        vecs[5] = '{12'h234, 1'b0, 8'h02, 8'hFF, 16'h5555, 16'hFFFA, 16'h0000,  37, 1'b0};
        vecs[6] = '{12'h812, 1'b0, 8'h80, 8'h80, 16'h1234, 16'h4000, 16'h0000,  51, 1'b0};
        vecs[7] = '{12'h234, 1'b1, 8'h02, 8'hFF, 16'h0003, 16'hFFFD, 16'h0003,  37, 1'b0};
        vecs[8] = '{12'h111, 1'b0, 8'h03, 8'hFE, 16'hABCD, 16'hFFFA, 16'h0000,  20, 1'b1};

        bus.start = 1'b0;
        bus.mnt   = '0;
        bus.mode  = 1'b0;

        // Reset state.
        #2;
        check("reset_ctl_outs", ctl_outs(), 64'd0);
        check("reset_wdata", bus.wdata_o, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vector(i, vecs[i]);

        // Rejected configurations: ERR pulse, no activity.
        for (int i = 0; i < 4; i++) begin
            en0 = en_cnt;
            bus.start = 1'b1;
            bus.mnt   = bad[i];
            @(negedge clk);
            bus.start = 1'b0;
            check($sformatf("err_pulse_%0d", i), 64'(bus.err), 64'd1);
            check($sformatf("err_busy_%0d", i), 64'(bus.busy), 64'd0);
            @(negedge clk);
            check($sformatf("err_one_cycle_%0d", i), 64'(bus.err), 64'd0);
            repeat (3) @(negedge clk);
            check($sformatf("err_no_sram_%0d", i), 64'(en_cnt - en0), 64'd0);
        end

        // Reset in the middle of a full job.
        load(vecs[0]);
        bus.start = 1'b1;
        bus.mnt   = 12'h888;
        bus.mode  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (39) @(negedge clk);
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctl_outs", ctl_outs(), 64'd0);
        check("abort_wdata", bus.wdata_o, 64'd0);
        en0 = en_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_sram", 64'(en_cnt - en0), 64'd0);
        run_vector(9, vecs[0]);

        check("enables_exclusive", 64'(ovl_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
